// File: rtl/xgmii_pkg.sv
// Shared XGMII code points, decoder state encoding and small helpers
// for the receive frame extractor.
package xgmii_pkg;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_PRE   = 8'h55;
  localparam logic [7:0] XGMII_SFD   = 8'hD5;

  localparam logic [63:0] XGMII_HDR   = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};
  localparam logic [7:0]  XGMII_HDR_C = 8'h01;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP} rx_state_e;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic        vld;
  } xgmii_word_t;

  // Byte-valid mask for a terminate in lane k (k=1..7): low k bits set.
  function automatic logic [7:0] keep_mask(input logic [2:0] k);
    return 8'hFF >> (4'd8 - {1'b0, k});
  endfunction
endpackage

// File: rtl/xgmii_rx_frame_extract_if.sv
// XGMII receive side plus the extracted-frame output stream.
interface xgmii_rx_frame_extract_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        align_status;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [7:0]  rx_keep;
  logic        rx_err;

  modport master (
    output xgmii_rxd, xgmii_rxc, align_status,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_keep, rx_err
  );
  modport slave (
    input  xgmii_rxd, xgmii_rxc, align_status,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_keep, rx_err
  );
endinterface

// File: rtl/xgmii_rx_lane_align.sv
// Re-aligns lane-4 starts onto lane 0. nxt is the aligned word for this cycle
// (used by the decoder as lookahead); cur_d is that word registered one cycle.
module xgmii_rx_lane_align
  import xgmii_pkg::*;
(
  input  logic        usrclk,
  input  logic        reset,
  input  xgmii_word_t raw,
  output xgmii_word_t nxt,
  output logic [63:0] cur_d
);
  logic        shift;
  logic [31:0] prev_d;
  logic [3:0]  prev_c;
  logic        start0, start4;

  assign start0 = raw.vld && raw.c[0] && (raw.d[7:0]   == XGMII_START);
  assign start4 = raw.vld && raw.c[4] && (raw.d[39:32] == XGMII_START);

  // A lane-0 start leaves shift mode at once: the upper half still buffered is
  // inter-frame gap, since minimum IPG rules out a terminate there.
  always_comb begin
    nxt = raw;
    if (shift && !start0) begin
      nxt.d = {raw.d[31:0], prev_d};
      nxt.c = {raw.c[3:0], prev_c};
    end
  end

  always_ff @(posedge usrclk) begin
    if (reset) begin
      shift  <= 1'b0;
      prev_d <= '0;
      prev_c <= '0;
      cur_d  <= '0;
    end else begin
      cur_d <= nxt.d;
      if (!raw.vld)    shift <= 1'b0;
      else if (start0) shift <= 1'b0;
      else if (start4) shift <= 1'b1;
      if (raw.vld) begin
        prev_d <= raw.d[63:32];
        prev_c <= raw.c[7:4];
      end
    end
  end
endmodule

// File: rtl/xgmii_rx_frame_extract.sv
// XGMII receive frame extractor: header check, one-word holdback, terminate/
// error/overflow handling and frame/error counters. Input-to-output latency 2.
module xgmii_rx_frame_extract
  import xgmii_pkg::*;
#(
  parameter int MAX_WORDS = 1200
) (
  input  logic                   usrclk,
  input  logic                   reset,
  xgmii_rx_frame_extract_if.slave bus,
  output logic [31:0]            frame_count,
  output logic [15:0]            err_count
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  xgmii_word_t raw, nxt;
  logic [63:0] cur_d;

  assign raw = '{d: bus.xgmii_rxd, c: bus.xgmii_rxc, vld: bus.align_status};

  xgmii_rx_lane_align u_align (
    .usrclk (usrclk),
    .reset  (reset),
    .raw    (raw),
    .nxt    (nxt),
    .cur_d  (cur_d)
  );

  // Classification of the lookahead word; lanes after a terminate are ignored.
  logic       has_t, ctl_bad, idle_only, is_start, hdr_ok;
  logic [2:0] t_pos;

  always_comb begin
    has_t     = 1'b0;
    t_pos     = 3'd0;
    ctl_bad   = 1'b0;
    idle_only = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!has_t && nxt.c[i]) begin
        if (nxt.d[8*i +: 8] == XGMII_TERM) begin
          has_t = 1'b1;
          t_pos = 3'(i);
        end else begin
          ctl_bad = 1'b1;
        end
      end
      if (!(nxt.c[i] && nxt.d[8*i +: 8] == XGMII_IDLE)) idle_only = 1'b0;
    end
  end

  assign is_start = nxt.c[0] && (nxt.d[7:0] == XGMII_START);
  assign hdr_ok   = (nxt.d == XGMII_HDR) && (nxt.c == XGMII_HDR_C);

  // cur_d is the held word; hold_fin marks it as the already-decided last word.
  rx_state_e   state, st_n;
  logic        hold_vld, hold_sof, hold_fin, hold_err;
  logic [7:0]  hold_keep;
  logic [CW-1:0] wcnt;

  logic        hv_n, hs_n, hf_n, he_n;
  logic [7:0]  hk_n;
  logic [CW-1:0] wc_n;
  logic        emit, e_eof, e_err, do_hdr;
  logic [7:0]  e_keep;
  logic [1:0]  drop, err_inc;
  logic        frame_inc;

  always_comb begin
    st_n   = state;
    hv_n   = 1'b0;
    hs_n   = 1'b0;
    hf_n   = 1'b0;
    he_n   = 1'b0;
    hk_n   = 8'hFF;
    wc_n   = wcnt;
    emit   = 1'b0;
    e_eof  = 1'b0;
    e_err  = 1'b0;
    e_keep = 8'hFF;
    do_hdr = 1'b0;
    drop   = 2'd0;

    if (hold_vld && hold_fin) begin
      emit   = 1'b1;
      e_eof  = 1'b1;
      e_err  = hold_err;
      e_keep = hold_keep;
    end

    if (!nxt.vld) begin
      if (state == ST_DATA) begin
        if (hold_vld) begin
          emit  = 1'b1;
          e_eof = 1'b1;
          e_err = 1'b1;
        end else begin
          drop = 2'd1;
        end
      end
      st_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: do_hdr = is_start;
        ST_DROP: if (has_t || idle_only) st_n = ST_IDLE;
        ST_DATA: begin
          if (is_start) begin
            if (hold_vld) begin
              emit  = 1'b1;
              e_eof = 1'b1;
              e_err = 1'b1;
            end else begin
              drop = 2'd1;
            end
            do_hdr = 1'b1;
          end else if (has_t && t_pos == 3'd0) begin
            if (hold_vld) begin
              emit  = 1'b1;
              e_eof = 1'b1;
            end else begin
              drop = 2'd1;
            end
            st_n = ST_IDLE;
          end else if (wcnt == CW'(MAX_WORDS)) begin
            // Word MAX_WORDS+1 arriving: truncate on the held word.
            emit  = 1'b1;
            e_eof = 1'b1;
            e_err = 1'b1;
            st_n  = has_t ? ST_IDLE : ST_DROP;
          end else begin
            emit = hold_vld;
            hv_n = 1'b1;
            hs_n = (wcnt == '0);
            wc_n = wcnt + CW'(1);
            if (ctl_bad) begin
              hf_n = 1'b1;
              he_n = 1'b1;
              st_n = has_t ? ST_IDLE : ST_DROP;
            end else if (has_t) begin
              hf_n = 1'b1;
              hk_n = keep_mask(t_pos);
              st_n = ST_IDLE;
            end
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end

    if (do_hdr) begin
      if (hdr_ok) begin
        st_n = ST_DATA;
        wc_n = '0;
      end else begin
        drop = drop + 2'd1;
        st_n = ST_DROP;
      end
    end
  end

  assign err_inc   = 2'(emit && e_eof && e_err) + drop;
  assign frame_inc = emit && e_eof && !e_err;

  logic [63:0] rx_data_q;
  logic [7:0]  rx_keep_q;
  logic        rx_valid_q, rx_sof_q, rx_eof_q, rx_err_q;

  always_ff @(posedge usrclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      hold_vld    <= 1'b0;
      hold_sof    <= 1'b0;
      hold_fin    <= 1'b0;
      hold_err    <= 1'b0;
      hold_keep   <= 8'hFF;
      wcnt        <= '0;
      rx_data_q   <= '0;
      rx_keep_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_sof_q    <= 1'b0;
      rx_eof_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      state      <= st_n;
      hold_vld   <= hv_n;
      hold_sof   <= hs_n;
      hold_fin   <= hf_n;
      hold_err   <= he_n;
      hold_keep  <= hk_n;
      wcnt       <= wc_n;
      rx_valid_q <= emit;
      rx_sof_q   <= emit && hold_sof;
      rx_eof_q   <= emit && e_eof;
      rx_err_q   <= emit && e_eof && e_err;
      rx_keep_q  <= emit ? e_keep : 8'h00;
      if (emit) rx_data_q <= cur_d;
      if (frame_inc && frame_count != 32'hFFFF_FFFF) frame_count <= frame_count + 32'd1;
      if (err_inc != 2'd0)
        err_count <= ({1'b0, err_count} + 17'(err_inc) > 17'h0FFFF) ? 16'hFFFF
                     : err_count + 16'(err_inc);
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_keep  = rx_keep_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_sof   = rx_sof_q;
  assign bus.rx_eof   = rx_eof_q;
  assign bus.rx_err   = rx_err_q;
endmodule

// File: tb/tb_xgmii_rx_frame_extract.sv
// Directed bench for xgmii_rx_frame_extract (MAX_WORDS=4): output words are
// logged with their cycle and checked against hand-derived expectations.
module tb_xgmii_rx_frame_extract;
  localparam logic [63:0] IDL  = 64'h0707070707070707;
  localparam logic [63:0] HDR  = 64'hD5555555555555FB;
  localparam logic [63:0] BADH = 64'hD4555555555555FB;
  localparam logic [63:0] TRM0 = 64'h07070707070707FD;
  localparam logic [63:0] D1   = 64'h1111111111111111;
  localparam logic [63:0] D2   = 64'h2222222222222222;
  localparam logic [63:0] D3   = 64'h3333333333333333;
  localparam logic [63:0] D4   = 64'h4444444444444444;
  localparam logic [63:0] D5   = 64'h5A5A5A5A5A5A5A5A;
  localparam logic [63:0] D6   = 64'h6666666666666666;

  logic        usrclk = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] frame_count;
  logic [15:0] err_count;
  int tests = 0, fails = 0, cyc = 0, t_in = 0;
  int c1, c2, c3, c4;

  typedef struct {
    int          cyc;
    logic [63:0] d;
    logic [7:0]  keep;
    logic        sof, eof, err;
  } obs_t;
  obs_t log_q[$];

  xgmii_rx_frame_extract_if bus();

  xgmii_rx_frame_extract #(.MAX_WORDS(4)) dut (
    .usrclk      (usrclk),
    .reset       (reset),
    .bus         (bus),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  always #5 usrclk = ~usrclk;
  always @(posedge usrclk) cyc <= cyc + 1;
  always @(negedge usrclk)
    if (bus.rx_valid)
      log_q.push_back('{cyc: cyc, d: bus.rx_data, keep: bus.rx_keep,
                        sof: bus.rx_sof, eof: bus.rx_eof, err: bus.rx_err});

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [63:0] bm(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic drv(input logic [63:0] d, input logic [7:0] c);
    bus.xgmii_rxd = d;
    bus.xgmii_rxc = c;
    t_in = cyc;
    @(posedge usrclk);
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) drv(IDL, 8'hFF);
  endtask

  task automatic chk_out(input string tag, input int idx, input logic [63:0] d,
                         input logic [7:0] keep, input logic sof, input logic eof,
                         input logic err, input int in_cyc);
    obs_t o;
    o = '{cyc: -100, d: '0, keep: '0, sof: 1'b0, eof: 1'b0, err: 1'b0};
    if (idx < log_q.size()) o = log_q[idx];
    check({tag, ".data"},  o.d & bm(keep), d & bm(keep));
    check({tag, ".flags"}, 64'({o.keep, o.sof, o.eof, o.err}), 64'({keep, sof, eof, err}));
    check({tag, ".lat"},   64'(o.cyc - in_cyc), 64'd2);
  endtask

  initial begin
    bus.xgmii_rxd    = IDL;
    bus.xgmii_rxc    = 8'hFF;
    bus.align_status = 1'b1;

    // Reset state
    idles(3);
    check("rst.flags", 64'({bus.rx_valid, bus.rx_sof, bus.rx_eof, bus.rx_err, bus.rx_keep}), 64'd0);
    check("rst.data", bus.rx_data, 64'd0);
    check("rst.cnt", 64'({frame_count, err_count}), 64'd0);
    reset = 1'b0;
    idles(2);

    // Lane-0 start, 3 words, terminate in lane 4
    log_q.delete();
    drv(HDR, 8'h01);
    drv(D1, 8'h00); c1 = t_in;
    drv(D2, 8'h00); c2 = t_in;
    drv(D3, 8'h00); c3 = t_in;
    drv(64'h070707FD44444444, 8'hF0); c4 = t_in;
    idles(3);
    check("s1.count", 64'(log_q.size()), 64'd4);
    chk_out("s1.w1", 0, D1, 8'hFF, 1, 0, 0, c1);
    chk_out("s1.w2", 1, D2, 8'hFF, 0, 0, 0, c2);
    chk_out("s1.w3", 2, D3, 8'hFF, 0, 0, 0, c3);
    chk_out("s1.w4", 3, 64'h0000000044444444, 8'h0F, 0, 1, 0, c4);
    check("s1.frames", 64'(frame_count), 64'd1);

    // Lane-4 start, 16-byte payload, terminate in lane 0 of next aligned word
    log_q.delete();
    drv(64'h555555FB07070707, 8'h1F);
    drv(64'h13121110D5555555, 8'h00);
    drv(64'h1B1A191817161514, 8'h00); c1 = t_in;
    drv(64'h070707FD1F1E1D1C, 8'hF0); c2 = t_in;
    idles(3);
    check("s2.count", 64'(log_q.size()), 64'd2);
    chk_out("s2.w1", 0, 64'h1716151413121110, 8'hFF, 1, 0, 0, c1);
    chk_out("s2.w2", 1, 64'h1F1E1D1C1B1A1918, 8'hFF, 0, 1, 0, c2);
    check("s2.frames", 64'(frame_count), 64'd2);

    // Error code in lane 3 of word 2; rest suppressed until terminate
    log_q.delete();
    drv(HDR, 8'h01);
    drv(D1, 8'h00); c1 = t_in;
    drv(64'h22222222FE222222, 8'h08); c2 = t_in;
    drv(D3, 8'h00);
    drv(TRM0, 8'hFF);
    idles(3);
    check("s3.count", 64'(log_q.size()), 64'd2);
    chk_out("s3.w1", 0, D1, 8'hFF, 1, 0, 0, c1);
    chk_out("s3.w2", 1, 64'h22222222FE222222, 8'hFF, 0, 1, 1, c2);
    check("s3.cnt", 64'({frame_count, err_count}), 64'({32'd2, 16'd1}));

    // Overflow: 6-word frame with MAX_WORDS=4
    log_q.delete();
    drv(HDR, 8'h01);
    drv(D1, 8'h00); drv(D2, 8'h00); drv(D3, 8'h00);
    drv(D4, 8'h00); c4 = t_in;
    drv(D5, 8'h00); drv(D6, 8'h00);
    drv(TRM0, 8'hFF);
    idles(4);
    check("s4.count", 64'(log_q.size()), 64'd4);
    chk_out("s4.w4", 3, D4, 8'hFF, 0, 1, 1, c4);
    check("s4.errs", 64'(err_count), 64'd2);

    // Exactly MAX_WORDS words is a good frame
    log_q.delete();
    drv(HDR, 8'h01);
    drv(D1, 8'h00); drv(D2, 8'h00); drv(D3, 8'h00);
    drv(D4, 8'h00); c4 = t_in;
    drv(TRM0, 8'hFF);
    idles(3);
    check("s4b.count", 64'(log_q.size()), 64'd4);
    chk_out("s4b.w4", 3, D4, 8'hFF, 0, 1, 0, c4);
    check("s4b.frames", 64'(frame_count), 64'd3);

    // Bad SFD dropped, then alignment lost mid-frame
    log_q.delete();
    drv(BADH, 8'h01);
    drv(D1, 8'h00); drv(D2, 8'h00);
    drv(TRM0, 8'hFF);
    idles(3);
    check("s5.badsfd.count", 64'(log_q.size()), 64'd0);
    check("s5.badsfd.errs", 64'(err_count), 64'd3);
    drv(HDR, 8'h01);
    drv(D1, 8'h00); c1 = t_in;
    drv(D2, 8'h00);
    drv(D3, 8'h00); c3 = t_in;
    bus.align_status = 1'b0;
    drv(D4, 8'h00);
    drv(D5, 8'h00);
    bus.align_status = 1'b1;
    idles(3);
    check("s5.count", 64'(log_q.size()), 64'd3);
    chk_out("s5.w1", 0, D1, 8'hFF, 1, 0, 0, c1);
    chk_out("s5.w3", 2, D3, 8'hFF, 0, 1, 1, c3);
    check("s5.errs", 64'(err_count), 64'd4);

    // Zero-length frame, then single-word frame with terminate in lane 3
    log_q.delete();
    drv(HDR, 8'h01);
    drv(TRM0, 8'hFF);
    idles(2);
    drv(HDR, 8'h01);
    drv(64'h07070707FD0C0B0A, 8'hF8); c1 = t_in;
    idles(3);
    check("s6.count", 64'(log_q.size()), 64'd1);
    chk_out("s6.w1", 0, 64'h0000000000_0C0B0A, 8'h07, 1, 1, 0, c1);
    check("s6.cnt", 64'({frame_count, err_count}), 64'({32'd4, 16'd5}));

    // Reset mid-frame abandons the frame; IDLE afterwards ignores payload
    log_q.delete();
    drv(HDR, 8'h01);
    drv(D1, 8'h00);
    drv(D2, 8'h00);
    reset = 1'b1;
    drv(D3, 8'h00);
    drv(D4, 8'h00);
    check("s7.rst.flags", 64'({bus.rx_valid, bus.rx_sof, bus.rx_eof, bus.rx_err, bus.rx_keep}), 64'd0);
    check("s7.rst.cnt", 64'({frame_count, err_count}), 64'd0);
    reset = 1'b0;
    drv(D5, 8'h00);
    drv(64'h070707FD44444444, 8'hF0);
    idles(3);
    check("s7.count", 64'(log_q.size()), 64'd1);
    check("s7.noeof", 64'(log_q.size() > 0 ? log_q[0].eof : 1'b1), 64'd0);
    check("s7.cnt", 64'({frame_count, err_count}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xgmii_rx_frame_extract.md
XGMII_RX_FRAME_EXTRACT -- requirements
Module: xgmii_rx_frame_extract

Interface
REQ-001 Parameter MAX_WORDS, default 1200, is the maximum number of 8-byte payload words per frame before the frame is truncated.
REQ-002 usrclk  in  1  single clock; every register is clocked on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 xgmii_rxd  in  64  XGMII receive data from the XAUI core; lane n = bits [8n+7:8n]; lane 0 is earliest in time.
REQ-005 xgmii_rxc  in  8  per-lane control flags for xgmii_rxd.
REQ-006 align_status  in  1  XAUI lane alignment achieved; 0 means the input is invalid.
REQ-007 rx_data  out  64  payload word, lane order preserved, preamble and SFD removed.
REQ-008 rx_valid  out  1  rx_data is valid this cycle; no backpressure.
REQ-009 rx_sof  out  1  first word of frame; qualified by rx_valid.
REQ-010 rx_eof  out  1  last word of frame; qualified by rx_valid.
REQ-011 rx_keep  out  8  per-lane byte valid; 8'hFF unless rx_eof; contiguous from lane 0.
REQ-012 rx_err  out  1  frame is bad; meaningful only with rx_eof.
REQ-013 frame_count  out  32  count of frames ended with rx_eof=1 and rx_err=0; saturates.
REQ-014 err_count  out  16  count of errored or dropped frames; saturates at 16'hFFFF.

Function
REQ-015 Codes used: Start 8'hFB, Terminate 8'hFD, Error 8'hFE, Idle 8'h07, Preamble 8'h55, SFD 8'hD5, each with rxc=1 where the code is a control code.
REQ-016 Alignment: a Start in lane 4 sets shift mode; a Start in lane 0 clears it. In shift mode the aligned word is {cur[31:0], prev[63:32]}, with rxc handled the same way; otherwise the aligned word is the current word.
REQ-017 Header check: the aligned Start word must be FB,55×6,D5 with rxc=8'h01. Any other Start word drops the frame: no output, err_count+1.
REQ-018 States: IDLE, DATA, DROP.
 - IDLE→DATA on a valid header.
 - DATA→IDLE on Terminate.
 - DATA→DROP on overflow.
 - DROP→IDLE on the first Terminate or Idle-only word.
REQ-019 Holdback: the decoder holds one payload word so that a Terminate in the following word's lane 0 marks the held word rx_eof with rx_keep=8'hFF.
REQ-020 Terminate in lane k (k=1..7) of an aligned word: that word is rx_eof with rx_keep having the low k bits set; the held word is emitted the cycle before.
REQ-021 Latency: 2 usrclk cycles from the cycle whose xgmii_rxd carries the last byte of an output word to that word on rx_data. The latency is identical in both alignment modes.
REQ-022 Zero-length frame (Start word followed by Terminate in lane 0): no output, err_count+1.
REQ-023 In DATA, any rxc bit set on a lane that is not Terminate (including Error): the current word is emitted with rx_eof=1, rx_err=1, rx_keep=8'hFF, then the block enters DROP.
REQ-024 Overflow: payload word number MAX_WORDS+1 is not emitted. Word MAX_WORDS is emitted with rx_eof=1 and rx_err=1, then the block enters DROP.
REQ-025 Start received while in DATA: the held word is emitted with rx_eof=1 and rx_err=1, and the new frame is processed normally.
REQ-026 align_status=0 in DATA: the held word is emitted with rx_eof=1 and rx_err=1, the block goes to IDLE and clears shift mode. Input is ignored while align_status=0.
REQ-027 Each errored-frame event increments err_count exactly once; rx_sof and rx_eof on one word (single-word frame) is legal.
REQ-028 Output protocol: every rx_sof is followed by exactly one rx_eof before the next rx_sof; rx_valid may deassert between them only at the alignment gap.

Reset
REQ-029 While reset=1, all of the following hold:
 - rx_valid, rx_sof, rx_eof and rx_err are 0.
 - rx_data is 0 and rx_keep is 0.
 - frame_count and err_count are 0.
 - state is IDLE and shift mode is cleared.
REQ-030 Reset asserted mid-frame abandons the frame without an rx_eof; the first cycle after reset is IDLE.

Structure
REQ-031 The XGMII code constants and the state enumeration are defined in the shared package xgmii_pkg.
REQ-032 Lane alignment (REQ-016) is implemented in the sub-module xgmii_rx_lane_align (registered, 1 cycle). The decoder and holdback are implemented in the top level.

Verification
REQ-033 Lane-0 Start, 3 payload words, Terminate in lane 4 → rx_sof on word 1, words 2–3 follow, rx_eof with rx_keep=8'h0F, frame_count=1.
REQ-034 Lane-4 Start, 16-byte payload, Terminate in lane 0 of the next aligned word → 2 words output, last word rx_keep=8'hFF, latency 2 cycles per REQ-021.
REQ-035 Error code 8'hFE in lane 3 of payload word 2 → word 2 is rx_eof with rx_err=1, err_count=1, and the rest of the frame is suppressed until Terminate.
REQ-036 MAX_WORDS=4, 6-word frame → 4 words output, the 4th with rx_eof=1 and rx_err=1, then nothing until the next Start.
REQ-037 Bad SFD (8'hD4) → no output, err_count=1; then align_status dropped mid-frame → rx_eof with rx_err=1, err_count=2.
